// File: rtl/multiphase_traffic_controller_if.sv
// rtl/multiphase_traffic_controller_if.sv - sensor/lamp bundle for the N-phase traffic controller
// Pedestrian signals exist only when TRAFFIC_PED_EN is defined.
interface multiphase_traffic_controller_if #(
    parameter int NUM_PHASES = 4
);
    localparam int PW = $clog2(NUM_PHASES);

    logic                    en;
    logic [NUM_PHASES-1:0]   high;
    logic [3*NUM_PHASES-1:0] lights;
    logic [PW-1:0]           phase;
    logic [2:0]              state;
`ifdef TRAFFIC_PED_EN
    logic                    ped_req;
    logic                    walk;

    modport master (
        output en, high, ped_req,
        input  lights, phase, state, walk
    );

    modport slave (
        input  en, high, ped_req,
        output lights, phase, state, walk
    );
`else
    modport master (
        output en, high,
        input  lights, phase, state
    );

    modport slave (
        input  en, high,
        output lights, phase, state
    );
`endif
endinterface

// File: rtl/multiphase_traffic_controller.sv
// rtl/multiphase_traffic_controller.sv - N-phase round-robin traffic-light controller
// Optional pedestrian WALK interval enabled by defining TRAFFIC_PED_EN.
module multiphase_traffic_controller #(
    parameter int NUM_PHASES   = 4,
    parameter int SHORT_GREEN  = 5,
    parameter int LONG_GREEN   = 10,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1,
    parameter int PED_TIME     = 4,
    parameter int CNT_W        = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    multiphase_traffic_controller_if.slave bus
);
    localparam int PW = $clog2(NUM_PHASES);
    localparam int CNT_RANGE = 1 << CNT_W;

    localparam logic [CNT_W-1:0] SG_LOAD = CNT_W'(SHORT_GREEN - 1);
    localparam logic [CNT_W-1:0] LG_LOAD = CNT_W'(LONG_GREEN - 1);
    localparam logic [CNT_W-1:0] YL_LOAD = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LOAD = (ALL_RED_TIME > 0) ? CNT_W'(ALL_RED_TIME - 1) : '0;

    if (NUM_PHASES < 2 || NUM_PHASES > 8 || SHORT_GREEN < 1 || LONG_GREEN < SHORT_GREEN ||
        YELLOW_TIME < 1 || ALL_RED_TIME < 0 || PED_TIME < 1 ||
        LONG_GREEN > CNT_RANGE || PED_TIME > CNT_RANGE ||
        YELLOW_TIME > CNT_RANGE || ALL_RED_TIME > CNT_RANGE) begin : g_param_check
        $error("multiphase_traffic_controller: illegal parameter set");
    end

`ifdef TRAFFIC_PED_EN
    localparam logic [CNT_W-1:0] PD_LOAD = CNT_W'(PED_TIME - 1);

    typedef enum logic [2:0] {
        S_GREEN   = 3'd0,
        S_YELLOW  = 3'd1,
        S_ALL_RED = 3'd2,
        S_HOLD    = 3'd3,
        S_WALK    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_GREEN   = 3'd0,
        S_YELLOW  = 3'd1,
        S_ALL_RED = 3'd2,
        S_HOLD    = 3'd3
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [CNT_W-1:0]        timer_q, timer_d;
    logic [3*NUM_PHASES-1:0] lights_q;
    logic [PW-1:0]           phase_inc;
    logic [CNT_W-1:0]        green_load;
    logic                    clear_exit;
`ifdef TRAFFIC_PED_EN
    logic                    ped_q;
    logic                    walk_q;
    logic                    ped_ok;
`endif

    // Lamp pattern for a given state/phase; only GREEN and YELLOW light a non-red lamp.
    function automatic logic [3*NUM_PHASES-1:0] decode(input state_t s, input logic [PW-1:0] p);
        logic [3*NUM_PHASES-1:0] l;
        for (int i = 0; i < NUM_PHASES; i++) begin
            l[3*i +: 3] = 3'b100;
            if (PW'(i) == p) begin
                if (s == S_GREEN) begin
                    l[3*i +: 3] = 3'b001;
                end else if (s == S_YELLOW) begin
                    l[3*i +: 3] = 3'b010;
                end
            end
        end
        return l;
    endfunction

    assign phase_inc  = (phase_q == PW'(NUM_PHASES - 1)) ? '0 : phase_q + 1'b1;
    assign green_load = bus.high[phase_inc] ? LG_LOAD : SG_LOAD;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        timer_d    = timer_q - 1'b1;
        clear_exit = 1'b0;
`ifdef TRAFFIC_PED_EN
        ped_ok     = 1'b1;
`endif
        case (state_q)
            S_GREEN: begin
                if (timer_q == '0 || !bus.en) begin
                    state_d = S_YELLOW;
                    timer_d = YL_LOAD;
                end
            end
            S_YELLOW: begin
                if (timer_q == '0) begin
                    if (ALL_RED_TIME > 0) begin
                        state_d = S_ALL_RED;
                        timer_d = AR_LOAD;
                    end else begin
                        clear_exit = 1'b1;
                    end
                end
            end
            S_ALL_RED: begin
                if (timer_q == '0) begin
                    clear_exit = 1'b1;
                end
            end
            S_HOLD: begin
                timer_d = timer_q;
                if (bus.en) begin
                    state_d = S_GREEN;
                    phase_d = phase_inc;
                    timer_d = green_load;
                end
            end
`ifdef TRAFFIC_PED_EN
            S_WALK: begin
                if (timer_q == '0) begin
                    clear_exit = 1'b1;
                    ped_ok     = 1'b0;
                end
            end
`endif
            default: begin
                state_d = S_ALL_RED;
                timer_d = '0;
            end
        endcase

        // Shared exit from a clearance interval (all-red, or yellow when all-red is skipped).
        if (clear_exit) begin
`ifdef TRAFFIC_PED_EN
            if (ped_ok && ped_q) begin
                state_d = S_WALK;
                timer_d = PD_LOAD;
            end else
`endif
            if (!bus.en) begin
                state_d = S_HOLD;
                timer_d = '0;
            end else begin
                state_d = S_GREEN;
                phase_d = phase_inc;
                timer_d = green_load;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_GREEN;
            phase_q  <= '0;
            timer_q  <= SG_LOAD;
            lights_q <= decode(S_GREEN, '0);
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            lights_q <= decode(state_d, phase_d);
        end
    end

`ifdef TRAFFIC_PED_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_q  <= 1'b0;
            walk_q <= 1'b0;
        end else begin
            walk_q <= (state_d == S_WALK);
            if (state_d == S_WALK && state_q != S_WALK) begin
                ped_q <= 1'b0;
            end else if (bus.ped_req) begin
                ped_q <= 1'b1;
            end
        end
    end

    assign bus.walk = walk_q;
`endif

    assign bus.lights = lights_q;
    assign bus.phase  = phase_q;
    assign bus.state  = state_q;
endmodule

// File: tb/tb_multiphase_traffic_controller.sv
// tb/tb_multiphase_traffic_controller.sv - self-checking bench for multiphase_traffic_controller
// Pedestrian scenario compiled in only with TRAFFIC_PED_EN.
module tb_multiphase_traffic_controller;
    localparam int NP  = 4;
    localparam int SG  = 5;
    localparam int LG  = 10;
    localparam int YT  = 2;
    localparam int ART = 1;
    localparam int PT  = 4;
    localparam int CW  = 4;
    localparam int PW  = $clog2(NP);
    localparam logic [3*NP-1:0] RESET_L = 12'b100_100_100_001;
    localparam logic [3*NP-1:0] ALLRED_L = 12'b100_100_100_100;

    logic clk = 1'b0;
    logic reset_n;
    logic ped_req;
    int   checks = 0;
    int   errors = 0;

    int   m_state, m_phase, m_el, m_len;
    bit   m_ped;

    multiphase_traffic_controller_if #(.NUM_PHASES(NP)) bus ();

    multiphase_traffic_controller #(
        .NUM_PHASES(NP), .SHORT_GREEN(SG), .LONG_GREEN(LG), .YELLOW_TIME(YT),
        .ALL_RED_TIME(ART), .PED_TIME(PT), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

`ifdef TRAFFIC_PED_EN
    assign bus.ped_req = ped_req;
`endif

    always #5 clk = ~clk;

    // Reference model: segment of kind m_state (0 G,1 Y,2 AR,3 HOLD,4 WALK) of length m_len, m_el cycles in.
    function automatic int nextp(input int p);
        return (p == NP - 1) ? 0 : p + 1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_el = 0; m_len = SG; m_ped = 0;
    endtask

    task automatic enter_green();
        m_phase = nextp(m_phase);
        m_state = 0;
        m_el    = 0;
        m_len   = bus.high[m_phase] ? LG : SG;
    endtask

    task automatic model_edge();
        bit last, clear, ped_ok, to_walk;
        last = (m_el == m_len - 1);
        clear = 0; ped_ok = 1; to_walk = 0;
        m_el = m_el + 1;
        case (m_state)
            0: if (last || !bus.en) begin m_state = 1; m_el = 0; m_len = YT; end
            1: if (last) begin
                   if (ART > 0) begin m_state = 2; m_el = 0; m_len = ART; end
                   else clear = 1;
               end
            2: clear = last;
            3: if (bus.en) enter_green();
            default: begin clear = last; ped_ok = 0; end
        endcase
        if (clear) begin
            if (ped_ok && m_ped) begin m_state = 4; m_el = 0; m_len = PT; to_walk = 1; end
            else if (!bus.en) m_state = 3;
            else enter_green();
        end
        if (to_walk) m_ped = 0;
        else if (ped_req) m_ped = 1;
    endtask

    function automatic logic [3*NP-1:0] exp_lights();
        logic [3*NP-1:0] l;
        l = '0;
        for (int p = 0; p < NP; p++)
            l[3*p +: 3] = (p != m_phase || m_state > 1) ? 3'b100 : ((m_state == 0) ? 3'b001 : 3'b010);
        return l;
    endfunction

    function automatic int nonred(input logic [3*NP-1:0] l);
        int n;
        n = 0;
        for (int p = 0; p < NP; p++) if (l[3*p +: 3] !== 3'b100) n++;
        return n;
    endfunction

    function automatic logic dut_walk();
`ifdef TRAFFIC_PED_EN
        return bus.walk;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; bus.en = 1'b1; bus.high = '0; ped_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.state !== 3'd0 || bus.phase !== '0) begin
            errors++; $display("FAIL reset_state state=%0d phase=%0d want 0/0", bus.state, bus.phase);
        end
        checks++;
        if (bus.lights !== RESET_L || dut_walk() !== 1'b0) begin
            errors++; $display("FAIL reset_lights lights=%b walk=%b want %b/0", bus.lights, dut_walk(), RESET_L);
        end
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_rotation();
        int g[NP];
        int wrap_at;
        bit seen3;
        for (int p = 0; p < NP; p++) g[p] = 0;
        wrap_at = -1; seen3 = 0;
        for (int c = 0; c <= 32; c++) begin
            if (seen3 && bus.phase == 0 && wrap_at < 0) wrap_at = c;
            if (bus.phase == 3) seen3 = 1;
            if (c < 32) begin
                if (bus.state == 3'd0) g[bus.phase]++;
                tick();
            end
        end
        checks++;
        if (wrap_at != 32 || bus.state !== 3'd0) begin
            errors++; $display("FAIL rotation_wrap wrap_cycle=%0d state=%0d want 32/0", wrap_at, bus.state);
        end
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (g[p] != SG) begin
                errors++; $display("FAIL rotation_green phase=%0d got=%0d want=%0d", p, g[p], SG);
            end
        end
    endtask

    task automatic test_high_held();
        int g[NP];
        int want;
        for (int p = 0; p < NP; p++) g[p] = 0;
        bus.high = 4'b0100;
        for (int c = 0; c < 37; c++) begin
            if (c == 36) begin
                checks++;
                if (bus.state !== 3'd2 || bus.phase !== 2'd3) begin
                    errors++; $display("FAIL high_period_end state=%0d phase=%0d want 2/3", bus.state, bus.phase);
                end
            end
            if (bus.state == 3'd0) g[bus.phase]++;
            tick();
        end
        checks++;
        if (bus.state !== 3'd0 || bus.phase !== 2'd0) begin
            errors++; $display("FAIL high_period state=%0d phase=%0d want 0/0", bus.state, bus.phase);
        end
        for (int p = 0; p < NP; p++) begin
            want = (p == 2) ? LG : SG;
            checks++;
            if (g[p] != want) begin
                errors++; $display("FAIL high_green phase=%0d got=%0d want=%0d", p, g[p], want);
            end
        end
        bus.high = '0;
    endtask

    task automatic test_high_pulse();
        int g[NP];
        for (int p = 0; p < NP; p++) g[p] = 0;
        for (int c = 0; c < 37; c++) begin
            bus.high = '0;
            if (c >= 10 && c <= 12) bus.high[1] = 1'b1;
            if (c == 15) bus.high[2] = 1'b1;
            if (bus.state == 3'd0) g[bus.phase]++;
            tick();
        end
        bus.high = '0;
        checks++;
        if (g[1] != SG) begin
            errors++; $display("FAIL pulse_ignored green1=%0d want=%0d", g[1], SG);
        end
        checks++;
        if (g[2] != LG) begin
            errors++; $display("FAIL pulse_entry green2=%0d want=%0d", g[2], LG);
        end
        checks++;
        if (bus.state !== 3'd0 || bus.phase !== 2'd0) begin
            errors++; $display("FAIL pulse_end state=%0d phase=%0d want 0/0", bus.state, bus.phase);
        end
    endtask

    task automatic test_en_hold();
        int es, ep;
        for (int c = 0; c <= 25; c++) begin
            if (c == 1) bus.en = 1'b0;
            if (c == 24) bus.en = 1'b1;
            es = (c < 2) ? 0 : (c < 4) ? 1 : (c == 4) ? 2 : (c < 25) ? 3 : 0;
            ep = (c < 25) ? 0 : 1;
            checks++;
            if (bus.state !== 3'(es) || bus.phase !== PW'(ep)) begin
                errors++; $display("FAIL en_hold cycle=%0d state=%0d phase=%0d want %0d/%0d",
                                   c, bus.state, bus.phase, es, ep);
            end
            if (c < 25) tick();
        end
    endtask

`ifdef TRAFFIC_PED_EN
    task automatic test_ped();
        bit ew;
        for (int c = 0; c <= 40; c++) begin
            ped_req = (c == 18 || c == 26);
            ew = (c >= 24 && c <= 27) || (c >= 36 && c <= 39);
            checks++;
            if (bus.walk !== ew || (ew && (bus.state !== 3'd4 || bus.lights !== ALLRED_L))) begin
                errors++; $display("FAIL ped_walk cycle=%0d walk=%b state=%0d lights=%b want walk=%b",
                                   c, bus.walk, bus.state, bus.lights, ew);
            end
            if (c == 28 || c == 40) begin
                checks++;
                if (bus.state !== 3'd0 || bus.phase !== PW'((c == 28) ? 0 : 1)) begin
                    errors++; $display("FAIL ped_resume cycle=%0d state=%0d phase=%0d", c, bus.state, bus.phase);
                end
            end
            if (c < 40) tick();
        end
        ped_req = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.en   = ($urandom_range(0, 9) != 0);
            bus.high = NP'($urandom);
`ifdef TRAFFIC_PED_EN
            ped_req  = ($urandom_range(0, 29) == 0);
`endif
            checks++;
            if ({bus.state, bus.phase, bus.lights, dut_walk()} !==
                {3'(m_state), PW'(m_phase), exp_lights(), (m_state == 4)}) begin
                errors++; $display("FAIL random cycle=%0d got s=%0d p=%0d l=%b w=%b want s=%0d p=%0d l=%b",
                                   c, bus.state, bus.phase, bus.lights, dut_walk(), m_state, m_phase, exp_lights());
            end
            checks++;
            if (nonred(bus.lights) > 1) begin
                errors++; $display("FAIL random_safety cycle=%0d lights=%b nonred=%0d want<=1",
                                   c, bus.lights, nonred(bus.lights));
            end
            tick();
        end
        bus.en = 1'b1; bus.high = '0; ped_req = 1'b0;
    endtask

    task automatic test_async_reset();
        bit found;
        int g0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (m_state == 1 && m_phase == 2 && m_el == 0) found = 1;
            else tick();
        end
        checks++;
        if (!found || bus.state !== 3'd1 || bus.phase !== 2'd2) begin
            errors++; $display("FAIL areset_setup found=%0d state=%0d phase=%0d want 1/2", found, bus.state, bus.phase);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.phase !== '0 || bus.lights !== RESET_L || dut_walk() !== 1'b0) begin
            errors++; $display("FAIL areset_async state=%0d phase=%0d lights=%b walk=%b want 0/0/%b/0",
                               bus.state, bus.phase, bus.lights, dut_walk(), RESET_L);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        g0 = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.state == 3'd0 && bus.phase == 0) g0++;
            checks++;
            if (nonred(bus.lights) > 1 || bus.lights !== exp_lights()) begin
                errors++; $display("FAIL areset_cycle cycle=%0d lights=%b want=%b", c, bus.lights, exp_lights());
            end
            tick();
        end
        checks++;
        if (g0 != SG) begin
            errors++; $display("FAIL areset_green got=%0d want=%0d", g0, SG);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_high_held();
        test_high_pulse();
        test_en_hold();
`ifdef TRAFFIC_PED_EN
        test_ped();
`endif
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
